luhn_checker: RTL and testbench

- Downstream of the PAN input stream stage. Consumes the gated digit stream of one PAN, left to right.
- Computes the Luhn (mod-10) checksum on the fly. Because the PAN length is unknown until the last digit, it keeps two running parity-hypothesis sums.
- Emits a one-cycle verdict with length and digit-validity qualifiers for the card-decision logic.

---
 rtl/luhn_checker.sv | 124 ++++++++++++
 tb/tb_luhn_checker.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/luhn_checker.sv
// Luhn (mod-10) checker for a PAN digit stream delivered left to right.
// The PAN length is only known at the last digit. The checker therefore
// keeps two running sums. sum_a doubles even indices and is the right
// answer for even-length PANs. sum_b doubles odd indices and is the right
// answer for odd-length PANs. The last beat picks the matching sum.
module luhn_checker #(
    parameter int MIN_LEN = 13,
    parameter int MAX_LEN = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] d_digit,
    input  logic       d_valid,
    input  logic       d_first,
    input  logic       d_last,
    input  logic       abort,
    output logic       busy,
    output logic       result_valid,
    output logic       luhn_ok,
    output logic [3:0] sum_mod10,
    output logic [4:0] len_out,
    output logic       length_ok,
    output logic       digit_err,
    output logic       proto_err,
    output logic       aborted
);

    typedef enum logic [1:0] {IDLE, ACCUM, RESULT} state_t;

    localparam logic [4:0] MIN_L = 5'(MIN_LEN);
    localparam logic [4:0] MAX_L = 5'(MAX_LEN);

    state_t     state;
    logic [3:0] sum_a, sum_b;
    logic [4:0] cnt;
    logic       bad;

    // Mod-10 add of two operands that are each already in the range 0..9.
    function automatic logic [3:0] add10(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 5'd10) s = s - 5'd10;
        return s[3:0];
    endfunction

    logic       in_pan, take, kill, d_bad;
    logic [4:0] idx, nxt_cnt;
    logic [3:0] base_a, base_b, dbl, c_a, c_b, nxt_a, nxt_b, sel_sum;
    logic       nxt_bad, nxt_lok;

    // Next-value datapath for an accepted beat. d_first restarts from zero.
    always_comb begin
        in_pan  = (state == ACCUM);
        take    = d_valid && (d_first || in_pan);
        kill    = abort && in_pan;
        idx     = d_first ? 5'd0 : cnt;
        base_a  = d_first ? 4'd0 : sum_a;
        base_b  = d_first ? 4'd0 : sum_b;
        d_bad   = (d_digit > 4'd9);
        dbl     = (d_digit <= 4'd4) ? 4'(d_digit << 1) : 4'((d_digit << 1) - 4'd9);
        // A digit above 9 contributes nothing, so the sums stay in 0..9.
        c_a     = d_bad ? 4'd0 : (idx[0] ? d_digit : dbl);
        c_b     = d_bad ? 4'd0 : (idx[0] ? dbl : d_digit);
        nxt_a   = add10(base_a, c_a);
        nxt_b   = add10(base_b, c_b);
        nxt_cnt = (idx == 5'd31) ? 5'd31 : idx + 5'd1;
        nxt_bad = (d_first ? 1'b0 : bad) | d_bad;
        nxt_lok = (nxt_cnt >= MIN_L) && (nxt_cnt <= MAX_L);
        sel_sum = nxt_cnt[0] ? nxt_b : nxt_a;
    end

    assign busy = in_pan;

    // Control FSM, accumulators and registered verdict. Abort wins over
    // same-cycle beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sum_a        <= '0;
            sum_b        <= '0;
            cnt          <= '0;
            bad          <= 1'b0;
            result_valid <= 1'b0;
            luhn_ok      <= 1'b0;
            sum_mod10    <= '0;
            len_out      <= '0;
            length_ok    <= 1'b0;
            digit_err    <= 1'b0;
            proto_err    <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            proto_err    <= 1'b0;
            aborted      <= 1'b0;
            if (kill) begin
                state   <= IDLE;
                aborted <= 1'b1;
            end else if (take) begin
                sum_a     <= nxt_a;
                sum_b     <= nxt_b;
                cnt       <= nxt_cnt;
                bad       <= nxt_bad;
                // A restart inside a PAN drops that PAN and flags it.
                proto_err <= in_pan && d_first;
                if (d_last) begin
                    state        <= RESULT;
                    result_valid <= 1'b1;
                    sum_mod10    <= sel_sum;
                    len_out      <= nxt_cnt;
                    length_ok    <= nxt_lok;
                    digit_err    <= nxt_bad;
                    luhn_ok      <= (sel_sum == 4'd0) && nxt_lok && !nxt_bad;
                end else begin
                    state <= ACCUM;
                end
            end else begin
                // A beat that arrives outside a PAN without d_first is dropped.
                if (d_valid) proto_err <= 1'b1;
                if (state == RESULT) state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_luhn_checker.sv
// Scoreboard bench for luhn_checker. Each PAN pushes its expected verdict,
// computed right-to-left in the textbook way. A negedge monitor pops that
// verdict and compares it when result_valid fires.
module tb_luhn_checker;

    logic       clk = 0, rst = 1;
    logic [3:0] d_digit = 0;
    logic       d_valid = 0, d_first = 0, d_last = 0, abort = 0;
    logic       busy, result_valid, luhn_ok, length_ok, digit_err, proto_err, aborted;
    logic [3:0] sum_mod10;
    logic [4:0] len_out;

    luhn_checker #(.MIN_LEN(13), .MAX_LEN(19)) dut (
        .clk(clk), .rst(rst), .d_digit(d_digit), .d_valid(d_valid),
        .d_first(d_first), .d_last(d_last), .abort(abort), .busy(busy),
        .result_valid(result_valid), .luhn_ok(luhn_ok), .sum_mod10(sum_mod10),
        .len_out(len_out), .length_ok(length_ok), .digit_err(digit_err),
        .proto_err(proto_err), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sum;
        logic [4:0] len;
        logic       lok, derr, ok;
    } exp_t;

    exp_t q[$];
    int   digs[$];
    int   tests = 0, fails = 0;

    // Scoreboard monitor. A result_valid with nothing expected is an error.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: result_valid=1 but none expected");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (len_out !== e.len || length_ok !== e.lok || digit_err !== e.derr ||
                    luhn_ok !== e.ok || (!e.derr && sum_mod10 !== e.sum)) begin
                    fails++;
                    $display("FAIL verdict: got len=%0d lok=%0b derr=%0b sum=%0d ok=%0b want len=%0d lok=%0b derr=%0b sum=%0d ok=%0b",
                             len_out, length_ok, digit_err, sum_mod10, luhn_ok,
                             e.len, e.lok, e.derr, e.sum, e.ok);
                end
            end
        end
    end

    function automatic exp_t model();
        exp_t e;
        int n, s, d, v;
        n = digs.size();
        s = 0;
        e.derr = 0;
        for (int j = 0; j < n; j++) begin
            d = digs[j];
            if (d > 9) e.derr = 1;
            else begin
                v = ((n - 1 - j) % 2 == 1) ? ((2 * d > 9) ? 2 * d - 9 : 2 * d) : d;
                s += v;
            end
        end
        e.sum = 4'(s % 10);
        e.len = 5'(n);
        e.lok = (n >= 13) && (n <= 19);
        e.ok  = (e.sum == 0) && e.lok && !e.derr;
        return e;
    endfunction

    task automatic drive(input logic [3:0] d, input logic v, input logic f, input logic l, input logic a);
        @(posedge clk); #1;
        d_digit = d; d_valid = v; d_first = f; d_last = l; abort = a;
    endtask

    task automatic idle();
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send all of digs as one PAN. exp_proto is the expected proto_err after
    // the first beat.
    task automatic send_pan(input logic exp_proto);
        int n;
        n = digs.size();
        q.push_back(model());
        for (int i = 0; i < n; i++) begin
            drive(4'(digs[i]), 1'b1, i == 0, i == n - 1, 1'b0);
            if (i == 1) begin
                tests++;
                if (proto_err !== exp_proto) begin
                    fails++;
                    $display("FAIL proto_after_first: got %0b want %0b", proto_err, exp_proto);
                end
            end
        end
    endtask

    // Send digs without a last beat, leaving the PAN open.
    task automatic send_partial();
        for (int i = 0; i < digs.size(); i++)
            drive(4'(digs[i]), 1'b1, i == 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, result_valid, luhn_ok, sum_mod10, len_out, length_ok, digit_err, proto_err, aborted} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got nonzero outputs, want all 0");
        end
        rst = 0;
    endtask

    task automatic test_valid_pans();
        digs = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};
        send_pan(1'b0); idle();
        digs = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,8};
        send_pan(1'b0); idle();
        digs = '{4,2,2,2,2,2,2,2,2,2,2,2,2};
        send_pan(1'b0); idle();
        idle();
    endtask

    task automatic test_length_bounds();
        digs = '{7,9,9,2,7,3,9,8,7,1,3};
        send_pan(1'b0); idle();
        digs = '{0};
        send_pan(1'b0); idle();
        // A 20-digit PAN exceeds the maximum length.
        digs = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        send_pan(1'b0); idle();
        idle();
    endtask

    task automatic test_digit_err();
        digs = '{4,5,3,9,12,4,8,8,0,3,4,3,6,4,6,7};
        send_pan(1'b0); idle();
        digs = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};
        send_pan(1'b0); idle();
        idle();
    endtask

    task automatic test_back_to_back();
        // The second PAN starts in the RESULT cycle of the first.
        digs = '{4,2,2,2,2,2,2,2,2,2,2,2,2};
        send_pan(1'b0);
        digs = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,8};
        send_pan(1'b0); idle();
        idle();
    endtask

    task automatic test_abort();
        digs = '{1,2,3,4,5,6,7,8};
        send_partial();
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        tests++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_pulse: got aborted=%0b busy=%0b want 1 0", aborted, busy);
        end
        idle();
        tests++;
        if (aborted !== 1'b0) begin
            fails++;
            $display("FAIL abort_one_cycle: got %0b want 0", aborted);
        end
        // Abort together with d_last: no verdict may appear.
        digs = '{1,2,3,4,5,6,7};
        send_partial();
        drive(4'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle();
        tests++;
        if (aborted !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_with_last: got aborted=%0b busy=%0b want 1 0", aborted, busy);
        end
        idle(); idle();
    endtask

    task automatic test_rst_mid_pan();
        digs = '{4,5,3,9,1,4,8,8,0,3};
        send_partial();
        @(posedge clk); #1;
        rst = 1; d_valid = 0; d_first = 0;
        @(posedge clk); #1;
        rst = 0;
        tests++;
        if ({busy, result_valid, luhn_ok, sum_mod10, len_out, length_ok, digit_err, proto_err, aborted} !== '0) begin
            fails++;
            $display("FAIL rst_mid_pan: got busy=%0b len=%0d ok=%0b want all 0", busy, len_out, luhn_ok);
        end
        idle();
    endtask

    task automatic test_proto();
        drive(4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        tests++;
        if (proto_err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL proto_idle: got proto=%0b busy=%0b want 1 0", proto_err, busy);
        end
        idle();
        // A second d_first in the middle of a PAN restarts it.
        digs = '{9,9,9,9,9};
        send_partial();
        digs = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};
        send_pan(1'b1); idle();
        idle();
    endtask

    initial begin
        test_reset();
        test_valid_pans();
        test_length_bounds();
        test_digit_err();
        test_back_to_back();
        test_abort();
        test_rst_mid_pan();
        test_proto();
        repeat (3) idle();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_results: %0d verdicts never arrived, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
